undolog_axil_regs: RTL and testbench
====================================

UNDOLOG_AXIL_REGS -- requirements
Module: undolog_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, meaning AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, meaning byte-address width (4 registers).
REQ-003 SHALL have port ACLK  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port ARESET  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports S_AXI_AWADDR in C_S_AXI_ADDR_WIDTH, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write address channel.
REQ-006 SHALL have ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write data channel.
REQ-007 SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response channel.
REQ-008 SHALL have ports S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address channel.
REQ-009 SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data channel.
REQ-010 SHALL have port INIT_AXI_TXN  out  1  one-cycle start pulse to the undolog master engines.

Function
REQ-011 SHALL hold four 32-bit read/write registers REG0..REG3 at byte offsets 0x0, 0x4, 0x8, 0xC, decoded from address bits [3:2]; bits [1:0] ignored.
REQ-012 SHALL assert AWREADY and WREADY together for exactly one cycle only when AWVALID, WVALID are both high, BVALID is low and neither ready is already high.
REQ-013 SHALL update the addressed register on that handshake edge, byte lane n written only when WSTRB[n]=1; other lanes keep value.
REQ-014 SHALL accept AW-before-W and W-before-AW, holding off both readies until the partner valid arrives; no address or data buffering.
REQ-015 SHALL raise BVALID the cycle after the write handshake with BRESP=2'b00 (OKAY), hold until BVALID&&BREADY, then drop; no new write accepted while BVALID high.
REQ-016 SHALL assert ARREADY for one cycle when ARVALID high, RVALID low and ARREADY low.
REQ-017 SHALL register RDATA from the addressed register on the AR handshake edge, raise RVALID the next cycle with RRESP=2'b00, hold RDATA stable until RVALID&&RREADY.
REQ-018 SHALL return the pre-write value when a read and write to the same register handshake in the same cycle (write-then-read ordering not guaranteed across channels).
REQ-019 SHALL process read and write channels independently; one outstanding transaction per channel; latency 2 cycles from valid to response with ready held high.
REQ-020 SHALL pulse INIT_AXI_TXN high for exactly one cycle the cycle after a write handshake to REG0 with WSTRB[0]=1 and WDATA[0]=1; REG0 bit0 retains the written value.
REQ-021 SHALL never return SLVERR or DECERR.

Reset
REQ-022 SHALL clear, asynchronously on ARESET high: REG0..REG3=0, AWREADY=0, WREADY=0, BVALID=0, BRESP=0, ARREADY=0, RVALID=0, RRESP=0, RDATA=0, INIT_AXI_TXN=0.
REQ-023 SHALL abandon any in-flight transaction on reset mid-operation; no response is issued for it after reset release.
REQ-024 SHALL accept new transactions from the first rising edge after ARESET deasserts.

Structure
REQ-025 SHALL place register offsets (0x0/0x4/0x8/0xC), RESP_OKAY encoding, and register count in shared package undolog_axil_pkg.
REQ-026 SHALL be a single module with write FSM (IDLE, RESP) and read FSM (IDLE, DATA); no sub-module.

Verification
REQ-027 SHALL cover: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, BRESP OKAY each; read back in order -> RDATA 0x1,0x2,0x3,0x4, RRESP OKAY.
REQ-028 SHALL cover: REG1=0xFFFFFFFF, write 0x12345678 WSTRB=4'b0101 -> read 0xFF34FF78.
REQ-029 SHALL cover: AWVALID 3 cycles before WVALID, BREADY low 5 cycles -> readies pulse once after WVALID, BVALID held 5 cycles, second write stalled until B handshake.
REQ-030 SHALL cover: REG2=0xA, same-cycle write 0xB to 0x8 and read 0x8 -> RDATA 0xA; subsequent read -> 0xB.
REQ-031 SHALL cover: write 0x1 to 0x0 -> INIT_AXI_TXN exactly one cycle high; write 0x1 with WSTRB=4'b1110 -> no pulse.
REQ-032 SHALL cover: ARESET asserted while BVALID high -> BVALID, all registers 0 immediately; no B after release; read 0x0 -> 0x0.

Source files
------------

// File: rtl/undolog_axil_pkg.sv
// ----------------------------------------------------------------------------
// undolog_axil_pkg
// Shared definitions for the undolog AXI4-Lite control register block:
// register map offsets, register count, response encoding and the state
// types of the write and read channel FSMs.
// ----------------------------------------------------------------------------
package undolog_axil_pkg;

  localparam int REG_COUNT = 4;

  // Byte offsets of the control registers; the word index is bits [3:2].
  localparam logic [3:0] REG0_OFFSET = 4'h0;
  localparam logic [3:0] REG1_OFFSET = 4'h4;
  localparam logic [3:0] REG2_OFFSET = 4'h8;
  localparam logic [3:0] REG3_OFFSET = 4'hC;

  localparam logic [1:0] REG0_IDX = REG0_OFFSET[3:2];

  // The block only ever answers OKAY.
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

endpackage : undolog_axil_pkg

// File: rtl/undolog_axil_regs.sv
// ----------------------------------------------------------------------------
// undolog_axil_regs
// AXI4-Lite slave with four 32-bit read/write control registers (REG0..REG3
// at byte offsets 0x0/0x4/0x8/0xC) and a one-cycle start pulse for the
// undolog master engines.
//
// Ports
//   ACLK, ARESET        : clock (rising edge), asynchronous active-high reset
//   S_AXI_AW*           : write address channel (AWPROT ignored)
//   S_AXI_W*            : write data channel with byte strobes
//   S_AXI_B*            : write response channel (always OKAY)
//   S_AXI_AR*           : read address channel (ARPROT ignored)
//   S_AXI_R*            : read data channel (always OKAY)
//   INIT_AXI_TXN        : one-cycle pulse after a write of 1 to REG0 bit 0
//
// One outstanding transaction per channel; no address/data buffering, so a
// write is only accepted once both AWVALID and WVALID are present.
// ----------------------------------------------------------------------------
module undolog_axil_regs
  import undolog_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,

  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,

  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,

  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,

  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,

  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,

  output logic                            INIT_AXI_TXN
);

  localparam int BYTES = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [REG_COUNT];

  wr_state_t wr_state, wr_state_next;
  rd_state_t rd_state, rd_state_next;

  logic       wr_ready_q;   // drives both AWREADY and WREADY
  logic       ar_ready_q;
  logic       wr_hs;
  logic       rd_hs;
  logic [1:0] wr_idx;
  logic [1:0] rd_idx;
  logic       init_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  // Protection bits and the sub-word address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_idx = S_AXI_AWADDR[3:2];
  assign rd_idx = S_AXI_ARADDR[3:2];

  // Readies only rise while both valids are up, so a ready high with valids
  // present is a complete handshake on this edge.
  assign wr_hs = wr_ready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_hs = ar_ready_q && S_AXI_ARVALID;

  // --------------------------------------------------------------------------
  // Write channel FSM
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; that is also what makes a same-cycle read of a
  // register being written return the old contents.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) wr_state <= WR_IDLE;
    else        wr_state <= wr_state_next;
  end

  // NOTE: the next-state value is defaulted before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_state_next = wr_state;
    case (wr_state)
      WR_IDLE: if (wr_hs)        wr_state_next = WR_RESP;
      WR_RESP: if (S_AXI_BREADY) wr_state_next = WR_IDLE;
      default:                   wr_state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ready_q <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      // One-cycle ready pulse: never re-armed while already high or while a
      // response is pending.
      wr_ready_q <= !wr_ready_q && S_AXI_AWVALID && S_AXI_WVALID &&
                    (wr_state == WR_IDLE);
      init_q     <= wr_hs && (wr_idx == REG0_IDX) &&
                    S_AXI_WSTRB[0] && S_AXI_WDATA[0];
    end
  end

  // NOTE: the register file is tiny and its reset value is architecturally
  // visible, so it is reset like any other flop rather than left as RAM.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int r = 0; r < REG_COUNT; r++) regs[r] <= '0;
    end else if (wr_hs) begin
      for (int b = 0; b < BYTES; b++) begin
        if (S_AXI_WSTRB[b]) regs[wr_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read channel FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rd_state <= RD_IDLE;
    else        rd_state <= rd_state_next;
  end

  always_comb begin
    rd_state_next = rd_state;
    case (rd_state)
      RD_IDLE: if (rd_hs)        rd_state_next = RD_DATA;
      RD_DATA: if (S_AXI_RREADY) rd_state_next = RD_IDLE;
      default:                   rd_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ar_ready_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ar_ready_q <= !ar_ready_q && S_AXI_ARVALID && (rd_state == RD_IDLE);
      // Captured only on the handshake, so RDATA holds until RREADY.
      if (rd_hs) rdata_q <= regs[rd_idx];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign S_AXI_AWREADY = wr_ready_q;
  assign S_AXI_WREADY  = wr_ready_q;
  assign S_AXI_BVALID  = (wr_state == WR_RESP);
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = (rd_state == RD_DATA);
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RDATA   = rdata_q;
  assign INIT_AXI_TXN  = init_q;

endmodule : undolog_axil_regs

// File: tb/tb_undolog_axil_regs.sv
// ----------------------------------------------------------------------------
// tb_undolog_axil_regs
// Self-checking bench for undolog_axil_regs. Directed scenarios plus a
// randomized write/read mix, all checked against a word/byte-lane model of
// the four registers. Inputs change and outputs are sampled on the falling
// clock edge.
// ----------------------------------------------------------------------------
module tb_undolog_axil_regs;
  import undolog_axil_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        INIT_AXI_TXN;

  undolog_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .INIT_AXI_TXN  (INIT_AXI_TXN)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: four words, updated lane by lane.
  logic [31:0] mdl [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // Wait (bounded) at falling edges until AWREADY is seen; returns cycles.
  task automatic wait_awready(output int cyc);
    cyc = 0;
    do begin
      @(negedge ACLK);
      cyc++;
    end while (!S_AXI_AWREADY && cyc < 20);
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int cyc;
    logic exp_init;
    exp_init = (addr[3:2] == 2'd0) && strb[0] && data[0];
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_BREADY  = 1'b1;
    wait_awready(cyc);
    check("awready", 32'(S_AXI_AWREADY), 32'd1);
    check("wready",  32'(S_AXI_WREADY),  32'd1);
    check("wr_ready_latency", cyc, 1);
    @(posedge ACLK);
    mdl[addr[3:2]] = merge(mdl[addr[3:2]], data, strb);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("bvalid",   32'(S_AXI_BVALID), 32'd1);
    check("bresp",    32'(S_AXI_BRESP),  32'(RESP_OKAY));
    check("init_hi",  32'(INIT_AXI_TXN), 32'(exp_init));
    @(negedge ACLK);
    check("bvalid_drop", 32'(S_AXI_BVALID), 32'd0);
    check("init_lo",     32'(INIT_AXI_TXN), 32'd0);
  endtask

  task automatic do_read(input logic [3:0] addr);
    int cyc = 0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY  = 1'b1;
    do begin
      @(negedge ACLK);
      cyc++;
    end while (!S_AXI_ARREADY && cyc < 20);
    check("arready", 32'(S_AXI_ARREADY), 32'd1);
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    check("rvalid", 32'(S_AXI_RVALID), 32'd1);
    check("rresp",  32'(S_AXI_RRESP),  32'(RESP_OKAY));
    check("rdata",  S_AXI_RDATA, mdl[addr[3:2]]);
    @(negedge ACLK);
    check("rvalid_drop", 32'(S_AXI_RVALID), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;

    repeat (3) @(negedge ACLK);
    check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
    check("rst_rdata",   S_AXI_RDATA,        32'd0);
    check("rst_init",    32'(INIT_AXI_TXN),  32'd0);
    ARESET = 1'b0;

    // Basic write/read of all four registers.
    do_write(REG0_OFFSET, 32'h1, 4'hF);
    do_write(REG1_OFFSET, 32'h2, 4'hF);
    do_write(REG2_OFFSET, 32'h3, 4'hF);
    do_write(REG3_OFFSET, 32'h4, 4'hF);
    for (int i = 0; i < 4; i++) do_read(4'(i * 4));

    // Byte strobes.
    do_write(REG1_OFFSET, 32'hFFFF_FFFF, 4'hF);
    do_write(REG1_OFFSET, 32'h1234_5678, 4'b0101);
    do_read(REG1_OFFSET);
    check("strobe_merge", mdl[1], 32'hFF34_FF78);

    // INIT pulse suppressed when lane 0 is not written.
    do_write(REG0_OFFSET, 32'h1, 4'b1110);

    // AW ahead of W, B stalled five cycles, second write held off.
    S_AXI_AWADDR  = REG1_OFFSET;
    S_AXI_WDATA   = 32'hCAFE_0001;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check("aw_only_no_ready", 32'(S_AXI_AWREADY), 32'd0);
    end
    S_AXI_WVALID = 1'b1;
    wait_awready(cyc);
    check("late_w_ready", 32'(S_AXI_AWREADY & S_AXI_WREADY), 32'd1);
    @(posedge ACLK);
    mdl[1] = 32'hCAFE_0001;
    @(negedge ACLK);
    check("ready_single_pulse", 32'(S_AXI_AWREADY), 32'd0);
    check("stall_bvalid0", 32'(S_AXI_BVALID), 32'd1);
    S_AXI_AWADDR = REG2_OFFSET;
    S_AXI_WDATA  = 32'hCAFE_0002;
    for (int i = 1; i < 5; i++) begin
      @(negedge ACLK);
      check("stall_bvalid", 32'(S_AXI_BVALID), 32'd1);
      check("stall_no_ready", 32'(S_AXI_AWREADY), 32'd0);
    end
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    check("b_done", 32'(S_AXI_BVALID), 32'd0);
    check("b_done_no_ready", 32'(S_AXI_AWREADY), 32'd0);
    @(negedge ACLK);
    check("second_wr_ready", 32'(S_AXI_AWREADY), 32'd1);
    @(posedge ACLK);
    mdl[2] = 32'hCAFE_0002;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("second_bvalid", 32'(S_AXI_BVALID), 32'd1);
    @(negedge ACLK);
    do_read(REG1_OFFSET);
    do_read(REG2_OFFSET);

    // Same-cycle write and read of REG2 returns the old value.
    do_write(REG2_OFFSET, 32'hA, 4'hF);
    S_AXI_AWADDR = REG2_OFFSET; S_AXI_WDATA = 32'hB; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = REG2_OFFSET;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    S_AXI_BREADY  = 1'b1; S_AXI_RREADY = 1'b1;
    wait_awready(cyc);
    check("coll_awready", 32'(S_AXI_AWREADY), 32'd1);
    check("coll_arready", 32'(S_AXI_ARREADY), 32'd1);
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    check("coll_rvalid", 32'(S_AXI_RVALID), 32'd1);
    check("coll_rdata_old", S_AXI_RDATA, 32'hA);
    mdl[2] = 32'hB;
    @(negedge ACLK);
    do_read(REG2_OFFSET);

    // Randomized mix; sub-word address bits are randomized and must be ignored.
    for (int i = 0; i < 60; i++) begin
      logic [1:0] idx;
      logic [3:0] addr;
      idx  = 2'($urandom_range(0, 3));
      addr = {idx, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1)
        do_write(addr, $urandom, 4'($urandom_range(0, 15)));
      else
        do_read(addr);
    end

    // Reset while a write response is pending.
    S_AXI_AWADDR = REG3_OFFSET; S_AXI_WDATA = 32'h5A5A_5A5A; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    wait_awready(cyc);
    check("rst_mid_awready", 32'(S_AXI_AWREADY), 32'd1);
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("rst_mid_bvalid", 32'(S_AXI_BVALID), 32'd1);
    ARESET = 1'b1;
    #1;
    check("async_rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("async_rst_rdata",  S_AXI_RDATA,       32'd0);
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    @(negedge ACLK);
    ARESET = 1'b0;
    S_AXI_BREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check("no_b_after_rst", 32'(S_AXI_BVALID), 32'd0);
    end
    for (int i = 0; i < 4; i++) do_read(4'(i * 4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_undolog_axil_regs
